// File: rtl/decimal_entry.sv
// Purpose: debounced decimal keypad entry; accumulates up to DIGITS digits into a W-bit binary value.
// Latency: raw button to FSM outputs is DB_CYCLES+4 edges (2 sync, DB_CYCLES debounce, 1 edge reg, 1 FSM).
// Backpressure: none; button events are consumed the cycle they arrive, value_valid is a bare strobe.

module decimal_entry_btn #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic evt_o
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          deb_prev_q;
    logic          evt_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronizer, debounce state and registered rising-edge detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            evt_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            evt_q      <= deb_q & ~deb_prev_q;
            cnt_q      <= cnt_d;
        end
    end

    // Count consecutive cycles of disagreement; any agreement (a bounce) restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign evt_o = evt_q;
endmodule

module decimal_entry #(
    parameter int W         = 8,
    parameter int DIGITS    = 3,
    parameter int DB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   dig,
    input  logic         btn_enter,
    input  logic         btn_done,
    output logic [W-1:0] value,
    output logic         value_valid,
    output logic [W-1:0] preview,
    output logic [1:0]   digit_count,
    output logic         err
);
    localparam int NW = W + 4;
    localparam logic [1:0] DIG_MAX = 2'(DIGITS);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ENTRY = 2'd1,
        S_FULL  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    logic enter_evt, done_evt;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [W-1:0]  value_q, value_d;
    logic          vld_q, vld_d;
    logic [NW-1:0] nxt;

    decimal_entry_btn #(.DB_CYCLES(DB_CYCLES)) u_enter (
        .clk   (clk),
        .reset (reset),
        .btn_i (btn_enter),
        .evt_o (enter_evt)
    );

    decimal_entry_btn #(.DB_CYCLES(DB_CYCLES)) u_done (
        .clk   (clk),
        .reset (reset),
        .btn_i (btn_done),
        .evt_o (done_evt)
    );

    // Widened so an out-of-range result is visible in the upper bits rather than wrapping.
    assign nxt = NW'(acc_q) * NW'(10) + NW'(dig);

    // FSM state, accumulator and committed value registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_EMPTY;
            acc_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            vld_q   <= vld_d;
        end
    end

    // Next-state logic; done wins over a coincident enter, which is dropped.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        vld_d   = 1'b0;
        if (done_evt) begin
            case (state_q)
                S_ENTRY, S_FULL: begin
                    value_d = acc_q;
                    vld_d   = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_EMPTY;
                end
                S_ERROR: begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_EMPTY;
                end
                default: ;
            endcase
        end else if (enter_evt) begin
            case (state_q)
                S_EMPTY, S_ENTRY: begin
                    if (dig > 4'd9 || nxt[NW-1:W] != '0) begin
                        state_d = S_ERROR;
                    end else begin
                        acc_d   = nxt[W-1:0];
                        cnt_d   = cnt_q + 2'd1;
                        state_d = (cnt_q + 2'd1 == DIG_MAX) ? S_FULL : S_ENTRY;
                    end
                end
                S_FULL:  state_d = S_ERROR;
                default: ;
            endcase
        end
    end

    assign value       = value_q;
    assign value_valid = vld_q;
    assign preview     = acc_q;
    assign digit_count = cnt_q;
    assign err         = (state_q == S_ERROR);
endmodule

// File: tb/tb_decimal_entry.sv
module tb_decimal_entry;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] dig = 4'd0;
    logic       btn_enter = 1'b0;
    logic       btn_done = 1'b0;
    logic [7:0] value;
    logic       value_valid;
    logic [7:0] preview;
    logic [1:0] digit_count;
    logic       err;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       is_done;
        logic [3:0] d;
        logic       commit;
        logic [7:0] pv;
        logic [1:0] dc;
        logic       er;
        logic [7:0] val;
    } vec_t;

    vec_t tbl[$];

    decimal_entry #(.W(8), .DIGITS(3), .DB_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .dig         (dig),
        .btn_enter   (btn_enter),
        .btn_done    (btn_done),
        .value       (value),
        .value_valid (value_valid),
        .preview     (preview),
        .digit_count (digit_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic is_done, input logic [3:0] d, input logic commit,
                                input logic [7:0] pv, input logic [1:0] dc, input logic er,
                                input logic [7:0] val);
        vec_t v;
        v.is_done = is_done; v.d = d; v.commit = commit;
        v.pv = pv; v.dc = dc; v.er = er; v.val = val;
        return v;
    endfunction

    // Every strobe must match the oldest pending expected commit.
    always @(negedge clk) begin
        if (value_valid === 1'b1) begin
            strobes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=%0d required=none", value);
            end else begin
                chk("commit_value", value, exp_q.pop_front());
            end
        end
    end

    // Press one or both buttons, hold long enough to be accepted, then release fully.
    task automatic press(input logic en, input logic dn, input logic [3:0] d);
        @(negedge clk);
        dig = d;
        btn_enter = en;
        btn_done = dn;
        repeat (10) @(posedge clk);
        @(negedge clk);
        btn_enter = 1'b0;
        btn_done = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_state(input string tag, input logic [7:0] pv, input logic [1:0] dc,
                             input logic er, input logic [7:0] val);
        chk({tag, "_preview"}, preview, pv);
        chk({tag, "_count"}, digit_count, dc);
        chk({tag, "_err"}, err, er);
        chk({tag, "_value"}, value, val);
    endtask

    initial begin
        // Scenario 1: asynchronous reset mid-cycle with random inputs.
        #3;
        dig = 4'($urandom);
        btn_enter = 1'($urandom);
        btn_done = 1'($urandom);
        reset = 1'b0;
        #1;
        chk_state("reset", 8'd0, 2'd0, 1'b0, 8'd0);
        chk("reset_valid", value_valid, 1'b0);
        btn_enter = 1'b0;
        btn_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Exact press-to-output latency: 8 edges with a 4-cycle debounce.
        dig = 4'd7;
        btn_enter = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("lat_edge7_preview", preview, 8'd0);
        @(posedge clk);
        #1;
        chk("lat_edge8_preview", preview, 8'd7);
        chk("lat_edge8_count", digit_count, 2'd1);
        @(negedge clk);
        btn_enter = 1'b0;
        repeat (10) @(posedge clk);
        exp_q.push_back(8'd7);
        press(1'b0, 1'b1, 4'd0);
        chk_state("commit7", 8'd0, 2'd0, 1'b0, 8'd7);

        // Scenarios 2, 3, 5 as a vector table.
        tbl.push_back(mk(0, 4'd2, 0, 8'd2,   2'd1, 0, 8'd7));
        tbl.push_back(mk(0, 4'd5, 0, 8'd25,  2'd2, 0, 8'd7));
        tbl.push_back(mk(0, 4'd5, 0, 8'd255, 2'd3, 0, 8'd7));
        tbl.push_back(mk(1, 4'd0, 1, 8'd0,   2'd0, 0, 8'd255));
        tbl.push_back(mk(0, 4'd2, 0, 8'd2,   2'd1, 0, 8'd255));
        tbl.push_back(mk(0, 4'd5, 0, 8'd25,  2'd2, 0, 8'd255));
        tbl.push_back(mk(0, 4'd6, 0, 8'd25,  2'd2, 1, 8'd255));
        tbl.push_back(mk(1, 4'd0, 0, 8'd0,   2'd0, 0, 8'd255));
        tbl.push_back(mk(0, 4'hA, 0, 8'd0,   2'd0, 1, 8'd255));
        tbl.push_back(mk(1, 4'd0, 0, 8'd0,   2'd0, 0, 8'd255));
        tbl.push_back(mk(0, 4'd1, 0, 8'd1,   2'd1, 0, 8'd255));
        tbl.push_back(mk(0, 4'd2, 0, 8'd12,  2'd2, 0, 8'd255));
        tbl.push_back(mk(0, 4'd3, 0, 8'd123, 2'd3, 0, 8'd255));
        tbl.push_back(mk(0, 4'd4, 0, 8'd123, 2'd3, 1, 8'd255));
        tbl.push_back(mk(1, 4'd0, 0, 8'd0,   2'd0, 0, 8'd255));
        tbl.push_back(mk(1, 4'd0, 0, 8'd0,   2'd0, 0, 8'd255));
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].commit) exp_q.push_back(tbl[i].val);
            press(!tbl[i].is_done, tbl[i].is_done, tbl[i].d);
            chk_state($sformatf("vec%0d", i), tbl[i].pv, tbl[i].dc, tbl[i].er, tbl[i].val);
        end

        // Scenario 4: bouncing contact, then a steady hold.
        @(negedge clk);
        dig = 4'd3;
        for (int i = 0; i < 10; i++) begin
            btn_enter = 1'b1;
            repeat (2) @(negedge clk);
            btn_enter = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("bounce_preview", preview, 8'd0);
        btn_enter = 1'b1;
        repeat (10) @(negedge clk);
        chk("bounce_hold_preview", preview, 8'd3);
        chk("bounce_hold_count", digit_count, 2'd1);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        dig = 4'd9;
        btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        btn_enter = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_preview", preview, 8'd3);
        chk("glitch_count", digit_count, 2'd1);
        exp_q.push_back(8'd3);
        press(1'b0, 1'b1, 4'd0);
        chk_state("commit3", 8'd0, 2'd0, 1'b0, 8'd3);

        // Scenario 6: simultaneous enter and done; done wins.
        press(1'b1, 1'b0, 4'd1);
        press(1'b1, 1'b0, 4'd2);
        chk("pre_simul_preview", preview, 8'd12);
        exp_q.push_back(8'd12);
        press(1'b1, 1'b1, 4'd5);
        chk_state("simul", 8'd0, 2'd0, 1'b0, 8'd12);

        // Reset in the middle of an entry discards it without a strobe.
        press(1'b1, 1'b0, 4'd4);
        press(1'b1, 1'b0, 4'd5);
        chk("pre_reset_preview", preview, 8'd45);
        #2;
        reset = 1'b0;
        #1;
        chk_state("midreset", 8'd0, 2'd0, 1'b0, 8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk_state("after_reset", 8'd0, 2'd0, 1'b0, 8'd0);

        chk("strobe_count", strobes, 4);
        chk("pending_commits", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decimal_entry.md
# decimal_entry

Front-end input block for the FPGA datapath, the input-side counterpart of the binary-to-decimal seven-segment display path. An operator keys an unsigned decimal number (up to 3 digits) from 4-bit digit switches, one debounced push-button press per digit. A second button commits the value. The block outputs the binary W-bit result with a one-cycle valid strobe, plus a running preview for the display.

## Interface

Parameters:

- W, 8, width of the binary result; the maximum accepted value is 2^W-1.
- DIGITS, 3, maximum number of decimal digits accepted per entry.
- DB_CYCLES, 16, number of consecutive stable cycles needed for the debouncer to accept a button level change (≥2).

Ports:

- clk, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, asynchronous, active-low; 0 clears all state immediately.
- dig, input, 4, digit switches, sampled on the enter event.
- btn_enter, input, 1, raw push-button (bouncy, asynchronous), appends a digit.
- btn_done, input, 1, raw push-button (bouncy, asynchronous), commits or clears the entry.
- value, output, W, last committed result; holds its value until the next commit.
- value_valid, output, 1, one-cycle pulse on the cycle `value` updates.
- preview, output, W, accumulator contents during entry.
- digit_count, output, 2, number of digits accepted so far (0..DIGITS).
- err, output, 1, high while in the ERROR state.

## Operation

Button conditioning (identical for each button):

- Two-flop synchronizer.
- Debounce counter: it increments each cycle the synchronized level differs from the debounced level, and resets to 0 when they match. When the counter reaches DB_CYCLES-1 while the levels still differ, the debounced level flips on that edge.
- A registered rising-edge detector produces a one-cycle event. Release produces no event.

FSM states:

- EMPTY: acc=0, digit_count=0.
- ENTRY: 1..DIGITS-1 digits accepted.
- FULL: DIGITS digits accepted.
- ERROR: err=1; acc and digit_count are frozen at their last good values.

Enter event:

- In EMPTY or ENTRY:
  - If dig>9, go to ERROR.
  - Otherwise compute next = acc*10 + dig at W+4 bits (no truncation).
  - If next > 2^W-1, go to ERROR.
  - Otherwise acc<=next, digit_count+=1, and the state becomes FULL when digit_count reaches DIGITS, else ENTRY.
- In FULL: go to ERROR.
- In ERROR: ignored.

Done event:

- In ENTRY or FULL: value<=acc, value_valid=1 for one cycle, acc<=0, digit_count<=0, go to EMPTY.
- In EMPTY: ignored; value is unchanged and there is no strobe.
- In ERROR: acc<=0, digit_count<=0, err<=0, go to EMPTY; value is unchanged and there is no strobe.

Other rules:

- Simultaneous enter and done events in the same cycle: done is processed and enter is discarded.
- preview always equals acc.
- Reset values: value=0, value_valid=0, preview=0, digit_count=0, err=0, state=EMPTY. Synchronizers, debounced levels, counters and edge registers are all cleared to 0.
- Reset mid-entry discards the partial entry. A button already held at reset release produces one event after the debounce period, because its debounced level starts at 0.

## Timing

- Button latency: raw input applied before edge 1 and held stable:
  - synchronizer output high after edge 2;
  - debounced level flips at edge DB_CYCLES+2;
  - event registered at edge DB_CYCLES+3;
  - FSM outputs (preview, digit_count, err, value, value_valid) update at edge DB_CYCLES+4.
- Glitch filtering: any raw pulse or bounce shorter than DB_CYCLES synchronized cycles is ignored. Each bounce resets the counter.
- value_valid is high for exactly one cycle per accepted commit. value changes only on that cycle.
- dig must be stable from the debounced flip through the event cycle. It is sampled in the cycle the FSM consumes the event.
- A new event on the same button requires a debounced release and a re-press. The minimum spacing is 2*DB_CYCLES cycles.

## Test plan

All scenarios use DB_CYCLES=4, W=8, DIGITS=3.

1. Reset: assert reset=0 mid-cycle with random inputs -> all outputs 0 immediately. Release, press enter (dig=7) -> preview=7 and digit_count=1 exactly 8 edges after the press.
2. Max value: enter 2, 5, 5, then done -> preview 2/25/255, digit_count 1/2/3; value=255 with value_valid high for one cycle; then preview=0, digit_count=0.
3. Overflow and invalid digit:
   - Enter 2, 5, 6 -> err=1 on the third event, preview stays 25, digit_count stays 2. Done -> err=0 with no valid strobe, and value keeps its prior contents.
   - Separately, dig=4'hA -> err=1.
4. Bounce: btn_enter toggles every 2 cycles for 20 cycles, then is held high (dig=3) -> exactly one digit is accepted (preview=3). A 3-cycle glitch alone is never accepted.
5. Extra digit: enter 1, 2, 3, 4 -> FULL after the third digit (preview=123), err=1 on the fourth. Done clears to EMPTY; done in EMPTY produces no strobe.
6. Simultaneous events: both buttons pressed on the same cycle with acc=12 -> value=12 and value_valid pulses; the digit is discarded and digit_count=0. Reset mid-entry at acc=45 -> preview=0 and no strobe.
